ocp_slave_mem: RTL and testbench
================================

// Module: ocp_slave_mem
// PURPOSE
// - OCP slave-side memory target. Sits directly downstream of the master memory bridge on the
//   shared ocp_if and services its RD/WR commands from a local register array.
// - Accepts one command at a time and returns a DVA/ERR response held until m_resp_accept.
// - Out-of-range addresses return ERR. Optional fixed wait states model slow memory.
// PARAMETERS
// - DATA_WIDTH   32  word width; must match ocp_if
// - ADDR_WIDTH   5   address width; must match ocp_if
// - DEPTH        32  implemented words, 1..2**ADDR_WIDTH; addr >= DEPTH is out of range
// - WAIT_CYCLES  2   extra response latency, 0..255; used only with OCP_SLAVE_WAIT_EN
// PORTS
// - clk            in   1           clock, rising edge
// - reset          in   1           asynchronous, active-high
// - enable         in   1           clock-enable; low freezes all state
// - s_ocp          ocp_if.slave     interface bundle; its fields follow:
// - .m_cmd         in   3           000 IDLE, 001 RD, 010 WR; others treated as IDLE
// - .m_addr        in   ADDR_WIDTH  word address
// - .m_data        in   DATA_WIDTH  write data
// - .s_cmd_accept  out  1           command accepted at this edge when m_cmd != IDLE
// - .s_resp        out  2           00 NULL, 01 DVA, 11 ERR
// - .s_data        out  DATA_WIDTH  read data; valid with s_resp=DVA on RD
// - .m_resp_accept in   1           master takes the response at this edge
// BEHAVIOUR
// - Reset values (async): state=IDLE, s_resp=00, s_data=0, wait counter=0. Memory array is not reset.
// - s_cmd_accept = enable && state==IDLE (combinational from state).
// - FSM states: IDLE, WAIT, RESP.
// - IDLE: edge with enable && m_cmd in {RD,WR}:
//   - capture cmd and addr; set in_range = (m_addr < DEPTH)
//   - WR && in_range: write mem[m_addr] <= m_data on this same edge
//   - without macro: go to RESP; with macro and WAIT_CYCLES>0: load counter=WAIT_CYCLES, go to WAIT
// - WAIT: counter decrements each enabled cycle; at 1 -> RESP on the next edge.
// - Entering RESP (registered):
//   - s_resp = DVA if in_range, else ERR
//   - RD && in_range: s_data = mem[addr]; otherwise s_data keeps its prior value
// - RESP: s_resp held stable until an enabled edge with m_resp_accept=1; on that edge s_resp<=00 and
//   state<=IDLE. New command accepted no earlier than the following cycle.
// - Latency, cmd-accept edge to s_resp valid: 1 cycle (+WAIT_CYCLES with macro).
// - m_cmd changes while not in IDLE are ignored. Strictly one outstanding transaction.
// - Unknown m_cmd codes (011..111) treated as IDLE; no accept.
// - enable low: no state/output/memory change; s_cmd_accept forced 0.
// - Reset mid-transaction: immediate return to IDLE with s_resp=00. A write already committed at
//   accept stays committed; the response is dropped.
// CONFIGURATION
// - OCP_SLAVE_WAIT_EN defined:
//   - WAIT state and an 8-bit counter exist; WAIT_CYCLES added to latency
//   - WAIT_CYCLES=0 behaves as undefined
// - OCP_SLAVE_WAIT_EN undefined: no WAIT state or counter; WAIT_CYCLES ignored.
// TESTING
// - WR addr=3 data=0xDEADBEEF:
//   - s_cmd_accept=1 at the cmd edge; next cycle s_resp=01
//   - held until m_resp_accept, then 00
// - RD addr=3 after that write -> s_resp=01, s_data=0xDEADBEEF one cycle after accept.
// - DEPTH=16, WR addr=20 then RD addr=20:
//   - both return s_resp=11
//   - s_data unchanged; mem[4] untouched
// - Hold m_resp_accept=0 for 5 cycles in RESP with a new m_cmd=RD driven:
//   - s_resp stays 01, s_cmd_accept stays 0
//   - RD accepted only after response taken
// - Assert reset in RESP:
//   - s_resp=00 and s_cmd_accept=1 immediately (enable high)
//   - prior write readable afterwards
// - With OCP_SLAVE_WAIT_EN, WAIT_CYCLES=3: RD accept -> s_resp=01 exactly 4 cycles later. Toggling
//   enable low for 2 cycles mid-WAIT extends this to 6.

Source files
------------

// File: rtl/ocp_slave_mem_if.sv
// OCP command/response bundle between a memory bridge (master) and a memory target (slave).
interface ocp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) ();
  logic [2:0]            m_cmd;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  s_cmd_accept;
  logic [1:0]            s_resp;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_resp_accept;

  modport master (
    output m_cmd, m_addr, m_data, m_resp_accept,
    input  s_cmd_accept, s_resp, s_data
  );

  modport slave (
    input  m_cmd, m_addr, m_data, m_resp_accept,
    output s_cmd_accept, s_resp, s_data
  );
endinterface

// File: rtl/ocp_slave_mem.sv
// OCP slave memory target: one outstanding RD/WR, DVA/ERR response held until m_resp_accept.
// Optional fixed wait states enabled by defining OCP_SLAVE_WAIT_EN.
module ocp_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  enable,
  ocp_if.slave  s_ocp
);

  localparam logic [2:0] CMD_RD    = 3'b001;
  localparam logic [2:0] CMD_WR    = 3'b010;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

`ifdef OCP_SLAVE_WAIT_EN
  localparam logic [7:0] LP_WAIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd2
  } state_t;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_cmd_vld;
  logic                  w_is_wr;
  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_resp_taken;
  logic                  w_src_wr;
  logic                  w_src_inr;
  logic [ADDR_WIDTH-1:0] w_src_addr;

  logic [1:0]            r_resp;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign w_cmd_vld  = (s_ocp.m_cmd == CMD_RD) || (s_ocp.m_cmd == CMD_WR);
  assign w_is_wr    = (s_ocp.m_cmd == CMD_WR);
  assign w_in_range = ({1'b0, s_ocp.m_addr} < LP_DEPTH);

`ifdef OCP_SLAVE_WAIT_EN
  logic                  r_cmd_wr;
  logic                  r_in_range;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_cnt;

  // Response is built from the live command when leaving IDLE, else from the captured one.
  assign w_src_wr   = (r_state == ST_IDLE) ? w_is_wr      : r_cmd_wr;
  assign w_src_inr  = (r_state == ST_IDLE) ? w_in_range   : r_in_range;
  assign w_src_addr = (r_state == ST_IDLE) ? s_ocp.m_addr : r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_wr   <= 1'b0;
      r_in_range <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= 8'd0;
    end else if (enable) begin
      if (w_accept) begin
        r_cmd_wr   <= w_is_wr;
        r_in_range <= w_in_range;
        r_addr     <= s_ocp.m_addr;
        r_cnt      <= LP_WAIT;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end
`else
  assign w_src_wr   = w_is_wr;
  assign w_src_inr  = w_in_range;
  assign w_src_addr = s_ocp.m_addr;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    w_resp_taken = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_vld) begin
          w_accept = 1'b1;
`ifdef OCP_SLAVE_WAIT_EN
          if (LP_WAIT != 8'd0) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt  = ST_RESP;
            w_enter_resp = 1'b1;
          end
`else
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
`endif
        end
      end
`ifdef OCP_SLAVE_WAIT_EN
      ST_WAIT: begin
        if (r_cnt <= 8'd1) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
        end
      end
`endif
      ST_RESP: begin
        if (s_ocp.m_resp_accept) begin
          w_state_nxt  = ST_IDLE;
          w_resp_taken = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_resp  <= RESP_NULL;
      r_data  <= '0;
    end else if (enable) begin
      r_state <= w_state_nxt;
      if (w_enter_resp) begin
        r_resp <= w_src_inr ? RESP_DVA : RESP_ERR;
        if (!w_src_wr && w_src_inr) begin
          r_data <= r_mem[w_src_addr];
        end
      end else if (w_resp_taken) begin
        r_resp <= RESP_NULL;
      end
    end
  end

  // Writes commit on the accept edge so a later reset cannot lose them.
  always_ff @(posedge clk) begin
    if (enable && w_accept && w_is_wr && w_in_range) begin
      r_mem[s_ocp.m_addr] <= s_ocp.m_data;
    end
  end

  assign s_ocp.s_cmd_accept = enable && (r_state == ST_IDLE);
  assign s_ocp.s_resp       = r_resp;
  assign s_ocp.s_data       = r_data;

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Directed bench for ocp_slave_mem (DEPTH=16, WAIT_CYCLES=3); latency expectation follows OCP_SLAVE_WAIT_EN.
module tb_ocp_slave_mem;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int WAITC = 3;
`ifdef OCP_SLAVE_WAIT_EN
  localparam int LAT = 1 + WAITC;
`else
  localparam int LAT = 1;
`endif

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_RD   = 3'b001;
  localparam logic [2:0] C_WR   = 3'b010;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  int   total = 0;
  int   bad   = 0;

  ocp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ocp_slave_mem #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_ocp(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and wait (bounded) for a non-NULL response.
  task automatic transact(input logic [2:0] cmd, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, output int lat);
    bus.m_cmd  = cmd;
    bus.m_addr = addr;
    bus.m_data = data;
    step();
    bus.m_cmd = C_IDLE;
    lat = 1;
    while (bus.s_resp == 2'b00 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic take();
    bus.m_resp_accept = 1'b1;
    step();
    bus.m_resp_accept = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    bus.m_cmd = C_IDLE; bus.m_addr = '0; bus.m_data = '0; bus.m_resp_accept = 1'b0;
    #12;
    total++; if (bus.s_resp !== 2'b00) begin bad++; $display("FAIL rst_resp got=%b exp=00", bus.s_resp); end
    total++; if (bus.s_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.s_data); end
    total++; if (bus.s_cmd_accept !== 1'b1) begin bad++; $display("FAIL rst_accept got=%b exp=1", bus.s_cmd_accept); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_write();
    int lat;
    bus.m_cmd = C_WR; bus.m_addr = 5'd3; bus.m_data = 32'hDEADBEEF;
    total++; if (bus.s_cmd_accept !== 1'b1) begin bad++; $display("FAIL wr_accept got=%b exp=1", bus.s_cmd_accept); end
    step();
    bus.m_cmd = C_IDLE;
    lat = 1;
    while (bus.s_resp == 2'b00 && lat < 20) begin step(); lat++; end
    total++; if (lat !== LAT) begin bad++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (bus.s_resp !== 2'b01) begin bad++; $display("FAIL wr_resp got=%b exp=01", bus.s_resp); end
    step(); step();
    total++; if (bus.s_resp !== 2'b01) begin bad++; $display("FAIL wr_resp_held got=%b exp=01", bus.s_resp); end
    take();
    total++; if (bus.s_resp !== 2'b00) begin bad++; $display("FAIL wr_resp_taken got=%b exp=00", bus.s_resp); end
    total++; if (bus.s_cmd_accept !== 1'b1) begin bad++; $display("FAIL wr_idle_accept got=%b exp=1", bus.s_cmd_accept); end
  endtask

  task automatic test_read();
    int lat;
    transact(C_RD, 5'd3, 32'h0, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (bus.s_resp !== 2'b01) begin bad++; $display("FAIL rd_resp got=%b exp=01", bus.s_resp); end
    total++; if (bus.s_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", bus.s_data); end
    take();
  endtask

  task automatic test_out_of_range();
    int lat;
    transact(C_WR, 5'd4, 32'h44444444, lat);
    take();
    transact(C_WR, 5'd20, 32'hBADBAD00, lat);
    total++; if (bus.s_resp !== 2'b11) begin bad++; $display("FAIL oor_wr_resp got=%b exp=11", bus.s_resp); end
    take();
    transact(C_RD, 5'd20, 32'h0, lat);
    total++; if (bus.s_resp !== 2'b11) begin bad++; $display("FAIL oor_rd_resp got=%b exp=11", bus.s_resp); end
    total++; if (bus.s_data !== 32'hDEADBEEF) begin bad++; $display("FAIL oor_rd_data got=%h exp=deadbeef", bus.s_data); end
    take();
    transact(C_RD, 5'd4, 32'h0, lat);
    total++; if (bus.s_data !== 32'h44444444) begin bad++; $display("FAIL oor_alias_data got=%h exp=44444444", bus.s_data); end
    take();
  endtask

  task automatic test_backpressure();
    int lat;
    transact(C_WR, 5'd7, 32'h00001234, lat);
    bus.m_cmd = C_RD; bus.m_addr = 5'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (bus.s_resp !== 2'b01) begin bad++; $display("FAIL bp_resp_held[%0d] got=%b exp=01", i, bus.s_resp); end
      total++; if (bus.s_cmd_accept !== 1'b0) begin bad++; $display("FAIL bp_no_accept[%0d] got=%b exp=0", i, bus.s_cmd_accept); end
    end
    take();
    total++; if (bus.s_resp !== 2'b00) begin bad++; $display("FAIL bp_taken got=%b exp=00", bus.s_resp); end
    total++; if (bus.s_cmd_accept !== 1'b1) begin bad++; $display("FAIL bp_accept_after got=%b exp=1", bus.s_cmd_accept); end
    step();
    bus.m_cmd = C_IDLE;
    lat = 1;
    while (bus.s_resp == 2'b00 && lat < 20) begin step(); lat++; end
    total++; if (lat !== LAT) begin bad++; $display("FAIL bp_rd_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (bus.s_data !== 32'h00001234) begin bad++; $display("FAIL bp_rd_data got=%h exp=00001234", bus.s_data); end
    take();
  endtask

  task automatic test_reset_mid();
    int lat;
    transact(C_WR, 5'd9, 32'hCAFEF00D, lat);
    #2 reset = 1'b1;
    #1;
    total++; if (bus.s_resp !== 2'b00) begin bad++; $display("FAIL midrst_resp got=%b exp=00", bus.s_resp); end
    total++; if (bus.s_cmd_accept !== 1'b1) begin bad++; $display("FAIL midrst_accept got=%b exp=1", bus.s_cmd_accept); end
    step();
    #2 reset = 1'b0;
    step();
    transact(C_RD, 5'd9, 32'h0, lat);
    total++; if (bus.s_resp !== 2'b01) begin bad++; $display("FAIL midrst_rd_resp got=%b exp=01", bus.s_resp); end
    total++; if (bus.s_data !== 32'hCAFEF00D) begin bad++; $display("FAIL midrst_rd_data got=%h exp=cafef00d", bus.s_data); end
    take();
  endtask

  task automatic test_enable();
    int lat;
    transact(C_WR, 5'd10, 32'h11111111, lat);
    take();
    enable = 1'b0;
    bus.m_cmd = C_WR; bus.m_addr = 5'd10; bus.m_data = 32'h55555555;
    #1;
    total++; if (bus.s_cmd_accept !== 1'b0) begin bad++; $display("FAIL en_accept_low got=%b exp=0", bus.s_cmd_accept); end
    step(); step();
    total++; if (bus.s_resp !== 2'b00) begin bad++; $display("FAIL en_no_resp got=%b exp=00", bus.s_resp); end
    bus.m_cmd = C_IDLE;
    enable = 1'b1;
    transact(C_RD, 5'd10, 32'h0, lat);
    total++; if (bus.s_data !== 32'h11111111) begin bad++; $display("FAIL en_mem_frozen got=%h exp=11111111", bus.s_data); end
    enable = 1'b0;
    bus.m_resp_accept = 1'b1;
    step(); step();
    total++; if (bus.s_resp !== 2'b01) begin bad++; $display("FAIL en_resp_frozen got=%b exp=01", bus.s_resp); end
    bus.m_resp_accept = 1'b0;
    enable = 1'b1;
    take();
    total++; if (bus.s_resp !== 2'b00) begin bad++; $display("FAIL en_resp_taken got=%b exp=00", bus.s_resp); end
  endtask

  task automatic test_unknown_cmd();
    int lat;
    bus.m_addr = 5'd3; bus.m_data = 32'h0;
    bus.m_cmd = 3'b011; step();
    bus.m_cmd = 3'b110; step();
    bus.m_cmd = 3'b111; step();
    total++; if (bus.s_resp !== 2'b00) begin bad++; $display("FAIL unk_no_resp got=%b exp=00", bus.s_resp); end
    total++; if (bus.s_cmd_accept !== 1'b1) begin bad++; $display("FAIL unk_still_idle got=%b exp=1", bus.s_cmd_accept); end
    bus.m_cmd = C_IDLE;
    transact(C_RD, 5'd3, 32'h0, lat);
    total++; if (bus.s_data !== 32'hDEADBEEF) begin bad++; $display("FAIL unk_mem_intact got=%h exp=deadbeef", bus.s_data); end
    take();
  endtask

`ifdef OCP_SLAVE_WAIT_EN
  task automatic test_wait_enable();
    int lat;
    bus.m_cmd = C_RD; bus.m_addr = 5'd3;
    step();
    bus.m_cmd = C_IDLE;
    lat = 1;
    step(); lat++;
    enable = 1'b0;
    step(); lat++;
    step(); lat++;
    enable = 1'b1;
    while (bus.s_resp == 2'b00 && lat < 20) begin step(); lat++; end
    total++; if (lat !== LAT + 2) begin bad++; $display("FAIL wait_en_latency got=%0d exp=%0d", lat, LAT + 2); end
    total++; if (bus.s_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wait_en_data got=%h exp=deadbeef", bus.s_data); end
    take();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_enable();
    test_unknown_cmd();
`ifdef OCP_SLAVE_WAIT_EN
    test_wait_enable();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
